// File: rtl/hazard_sched.sv
// Hazard controller for the 5-stage RV32I pipe: operand forwarding selects,
// load-use / branch stall-flush control, and a memory-wait hold with timeout.
module hazard_sched #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rdD,
  input  logic             reg_writeD,
  input  logic [1:0]       res_srcD,
  input  logic             mem_accD,
  input  logic             pc_srcE,
  input  logic             dmem_ready,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             stallF,
  output logic             stallD,
  output logic             flushD,
  output logic             flushE,
  output logic             stall_all,
  output logic             err_timeout,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  logic [4:0]       rs1E, rs2E, rdE, rdM, rdW;
  logic             rwE, loadE, memE, rwM, memM, rwW;
  state_t           state;
  logic [WC_W-1:0]  wait_cnt;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_hit, mem_wait, lw_stall;

  assign timeout_hit = (state == S_WAIT) && (wait_cnt == WC_W'(MEM_TIMEOUT));
  assign mem_wait    = memM && !dmem_ready && !timeout_hit;
  assign lw_stall    = loadE && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));

  // Forwards depend only on tracking registers, never on dmem_ready.
  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    stallF    = 1'b0;
    stallD    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    stall_all = 1'b0;
    if (!reset) begin
      if (rwM && rdM != 5'd0 && rdM == rs1E)      forwardAE = 2'b10;
      else if (rwW && rdW != 5'd0 && rdW == rs1E) forwardAE = 2'b01;
      if (rwM && rdM != 5'd0 && rdM == rs2E)      forwardBE = 2'b10;
      else if (rwW && rdW != 5'd0 && rdW == rs2E) forwardBE = 2'b01;
      if (mem_wait) begin
        stall_all = 1'b1;
        stallF    = 1'b1;
        stallD    = 1'b1;
      end else if (pc_srcE) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end else if (lw_stall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
    end
  end

  assign err_timeout  = err_q && !reset;
  assign stall_cycles = reset ? '0 : cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rs1E <= '0; rs2E <= '0; rdE <= '0; rwE <= 1'b0; loadE <= 1'b0; memE <= 1'b0;
      rdM <= '0; rwM <= 1'b0; memM <= 1'b0;
      rdW <= '0; rwW <= 1'b0;
      state    <= S_IDLE;
      wait_cnt <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (!stall_all) begin
        rdM <= rdE; rwM <= rwE; memM <= memE;
        rdW <= rdM; rwW <= rwM;
        if (flushE) begin
          rs1E <= '0; rs2E <= '0; rdE <= '0; rwE <= 1'b0; loadE <= 1'b0; memE <= 1'b0;
        end else begin
          rs1E  <= rs1D;
          rs2E  <= rs2D;
          rdE   <= rdD;
          rwE   <= reg_writeD;
          loadE <= (res_srcD == 2'b01);
          memE  <= mem_accD;
        end
      end
      case (state)
        S_IDLE:
          if (mem_wait) begin
            state    <= S_WAIT;
            wait_cnt <= WC_W'(1);
          end
        S_WAIT:
          if (timeout_hit) begin
            state <= S_IDLE;
            err_q <= 1'b1;
          end else if (!mem_wait) begin
            state <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        default: state <= S_IDLE;
      endcase
      if (stallF && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule
